// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, default data width and controller state encoding shared by the ALU arbiter.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ADD  = 3'b001;
  localparam logic [2:0] ADDI = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] SUBI = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);
  logic [ID_W-1:0] k;
  // Scan from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    k = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = ID_W'((int'(last) + i) % N_REQ);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU among N_REQ requesters.
// Optional ALU_ARB_OVF_EN adds a registered rsp_ovf overflow flag.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = alu_pkg::DATA_W,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [3*N_REQ-1:0]         req_opcode,
  input  logic [DATA_W*N_REQ-1:0]    req_a,
  input  logic [DATA_W*N_REQ-1:0]    req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic signed [DATA_W-1:0]   rsp_result,
  output logic [2:0]                 alu_opcode,
  output logic signed [DATA_W-1:0]   alu_a,
  output logic signed [DATA_W-1:0]   alu_b,
  input  logic signed [DATA_W-1:0]   alu_result,
`ifdef ALU_ARB_OVF_EN
  output logic                       rsp_ovf,
`endif
  output logic                       busy
);
  state_t state;
  logic [ID_W-1:0] last_grant, gidx;
  logic [N_REQ-1:0] gnt;
  logic [2:0] op_q;
  logic signed [DATA_W-1:0] a_q, b_q;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (.req(req_valid), .last(last_grant), .gnt(gnt), .idx(gidx));
  assign req_ready  = (state == IDLE) ? gnt : '0;
  assign busy       = state != IDLE;
  assign alu_opcode = (state == EXEC) ? op_q : NOP;
  assign alu_a      = (state == EXEC) ? a_q : '0;
  assign alu_b      = (state == EXEC) ? b_q : '0;
`ifdef ALU_ARB_OVF_EN
  logic signed [DATA_W-1:0] sum, dif;
  logic signed [2*DATA_W-1:0] prod;
  logic ovf;
  always_comb begin
    sum = a_q + b_q;
    dif = a_q - b_q;
    prod = (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);
    ovf = (op_q == ADD || op_q == ADDI) ? (a_q[DATA_W-1] == b_q[DATA_W-1] && sum[DATA_W-1] != a_q[DATA_W-1]) :
          (op_q == SUB || op_q == SUBI) ? (a_q[DATA_W-1] != b_q[DATA_W-1] && dif[DATA_W-1] != a_q[DATA_W-1]) :
          (op_q == MUL) ? !(&prod[2*DATA_W-1:DATA_W-1] || ~|prod[2*DATA_W-1:DATA_W-1]) : 1'b0;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      op_q <= NOP;
      a_q <= '0;
      b_q <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
`ifdef ALU_ARB_OVF_EN
      rsp_ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          op_q <= req_opcode[3*int'(gidx) +: 3];
          a_q <= req_a[DATA_W*int'(gidx) +: DATA_W];
          b_q <= req_b[DATA_W*int'(gidx) +: DATA_W];
          last_grant <= gidx;
          state <= EXEC;
        end
        EXEC: state <= WAIT;
        WAIT: begin
          rsp_result <= alu_result;
          rsp_valid <= 1'b1;
          rsp_id <= last_grant;
`ifdef ALU_ARB_OVF_EN
          rsp_ovf <= ovf;
`endif
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a behavioural registered ALU; define ALU_ARB_OVF_EN to check rsp_ovf.
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk, rst, rsp_valid, rsp_ready, busy;
  logic [3:0] valid, req_ready;
  logic [11:0] req_opcode;
  logic [63:0] req_a, req_b;
  logic [1:0] rsp_id;
  logic [15:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;
  logic [2:0] opc [4];
  logic [15:0] av [4], bv [4];
`ifdef ALU_ARB_OVF_EN
  logic rsp_ovf;
`endif
  typedef struct {int id; logic [15:0] res; logic ovf;} exp_t;
  exp_t sb [$];
  int gcyc [$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  alu_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
`ifdef ALU_ARB_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < 4; i++) begin
      req_opcode[3*i +: 3] = opc[i];
      req_a[16*i +: 16] = av[i];
      req_b[16*i +: 16] = bv[i];
    end
  function automatic logic [15:0] alu_f(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    return (o == ADD || o == ADDI) ? x + y : (o == SUB || o == SUBI) ? x - y : (o == MUL) ? 16'(x * y) : 16'h0;
  endfunction
  always @(posedge clk) begin
    alu_result <= rst ? 16'h0 : alu_f(alu_opcode, alu_a, alu_b);
    cyc <= cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void push(input int id, input logic [15:0] r, input logic o);
    sb.push_back('{id, r, o});
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("rsp_extra", {31'b0, rsp_valid}, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_res", rsp_result, e.res);
`ifdef ALU_ARB_OVF_EN
        chk("rsp_ovf", rsp_ovf, e.ovf);
`endif
      end
    end
    if (!rst && |req_ready) gcyc.push_back(cyc);
  end
  task automatic req_drive(input int id, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    bit ok = 0;
    valid[id] = 1'b1; opc[id] = o; av[id] = x; bv[id] = y;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready[id];
    end
    if (!ok) chk("grant_timeout", req_ready[id], 1);
    @(posedge clk); #1;
    valid[id] = 1'b0;
  endtask
  task automatic wait_done();
    bit ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = sb.size() == 0 && !busy;
    end
    if (!ok) chk("done_timeout", sb.size(), 0);
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    rst = 1; valid = '0; rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin opc[i] = 0; av[i] = 0; bv[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_id", rsp_id, 0); chk("rst_rsp_res", rsp_result, 0);
    chk("rst_alu_op", alu_opcode, 0); chk("rst_alu_a", alu_a, 0); chk("rst_alu_b", alu_b, 0);
    chk("rst_busy", busy, 0); chk("rst_ready", req_ready, 0);
    @(posedge clk); #1 rst = 0;
    // single ADD with cycle-accurate latency
    @(posedge clk); #1;
    push(0, 16'd70, 0);
    valid[0] = 1; opc[0] = ADD; av[0] = 16'd100; bv[0] = -16'sd30;
    @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
    @(posedge clk); #1 valid[0] = 0;
    @(negedge clk); chk("t1_alu_op", alu_opcode, ADD); chk("t1_alu_a", alu_a, 16'd100);
    chk("t1_alu_b", alu_b, 16'hFFE2); chk("t1_busy", busy, 1);
    @(negedge clk); chk("t1_early", rsp_valid, 0); chk("t1_alu_idle", alu_opcode, NOP);
    @(negedge clk); chk("t1_rsp_valid", rsp_valid, 1);
    @(negedge clk); chk("t1_busy_low", busy, 0);
    // four contending SUBs, requester 0 twice
    do_reset();
    gcyc.delete();
    for (int i = 0; i < 4; i++) push(i, 16'(i - 1), 0);
    push(0, 16'hFFFF, 0);
    fork
      begin req_drive(0, SUB, 0, 1); req_drive(0, SUB, 0, 1); end
      req_drive(1, SUB, 1, 1);
      req_drive(2, SUB, 2, 1);
      req_drive(3, SUB, 3, 1);
    join
    wait_done();
    chk("t2_ngrant", gcyc.size(), 5);
    for (int k = 1; k < gcyc.size(); k++) chk("t2_gap", gcyc[k] - gcyc[k-1], 4);
    // backpressure with a competing request
    @(posedge clk); #1 rsp_ready = 0;
    push(1, 16'h5F90, 1);
    push(2, 16'd11, 0);
    fork
      req_drive(1, MUL, 16'd300, 16'd300);
      req_drive(2, ADD, 16'd5, 16'd6);
      begin
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = rsp_valid; end
        chk("t3_rsp_seen", rsp_valid, 1);
        repeat (5) begin
          @(negedge clk);
          chk("t3_hold_res", rsp_result, 16'h5F90); chk("t3_hold_id", rsp_id, 1);
          chk("t3_no_grant", req_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1;
      end
    join
    wait_done();
    // signed wrap
    @(posedge clk); #1;
    push(3, 16'h8000, 1);
    req_drive(3, ADD, 16'd32767, 16'd1);
    wait_done();
    // reset during WAIT of a req2 op
    @(posedge clk); #1;
    valid[2] = 1; opc[2] = ADD; av[2] = 16'd40; bv[2] = 16'd2;
    @(negedge clk); chk("t5_ready", req_ready, 4'b0100);
    @(posedge clk); #1 valid[2] = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t5_rsp_valid", rsp_valid, 0); chk("t5_rsp_id", rsp_id, 0); chk("t5_rsp_res", rsp_result, 0);
    chk("t5_alu_op", alu_opcode, 0); chk("t5_alu_a", alu_a, 0); chk("t5_busy", busy, 0);
    @(posedge clk); #1;
    push(0, 16'd3, 0);
    push(2, 16'd7, 0);
    fork
      req_drive(0, ADD, 16'd1, 16'd2);
      req_drive(2, SUB, 16'd10, 16'd3);
    join
    wait_done();
    // unsupported opcode plus mixed traffic
    @(posedge clk); #1;
    push(3, 16'h7FFF, 1);
    push(0, 16'h63C0, 1);
    push(1, 16'h0000, 0);
    push(2, 16'hFFEB, 0);
    push(1, 16'h7FFF, 1);
    fork
      req_drive(3, SUBI, 16'h8000, 16'd1);
      req_drive(0, MUL, -16'sd200, 16'd200);
      begin req_drive(1, 3'b111, 16'd5, 16'd5); req_drive(1, ADDI, 16'h8000, 16'hFFFF); end
      req_drive(2, MUL, -16'sd3, 16'd7);
    join
    wait_done();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between N_REQ requesters (fetch/decode lanes, address-gen, debug port).
- Round-robin arbitration and a valid/ready handshake on both the request and response sides.
- Sequences each operation through the ALU's one-cycle registered result, then returns the result tagged with the requester index.
- Sits between the requesters and the ALU; the ALU's active-low reset is tied to ~rst at integration.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand/result width, signed
- ID_W (localparam), $clog2(N_REQ), requester index width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_opcode  in  3*N_REQ  packed opcodes, requester i at [3i+2:3i]
- req_a  in  DATA_W*N_REQ  packed signed operand A
- req_b  in  DATA_W*N_REQ  packed signed operand B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of requester being answered
- rsp_result  out  DATA_W  signed result
- alu_opcode  out  3  to ALU
- alu_a  out  DATA_W  to ALU
- alu_b  out  DATA_W  to ALU
- alu_result  in  DATA_W  from ALU, registered one clock after inputs
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC, WAIT, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, alu_opcode=3'b000, alu_a=0, alu_b=0, busy=0, req_ready=0. The round-robin pointer last_grant resets to N_REQ-1, so requester 0 wins first.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from last_grant+1 modulo N_REQ.
  - req_ready[g] is asserted combinationally in the same cycle.
  - On that edge: latch opcode/a/b and g, set last_grant=g, go to EXEC.
  - With no valid requests: stay in IDLE, all req_ready=0.
- EXEC: drive alu_opcode/alu_a/alu_b from the latched values for exactly one cycle, then go to WAIT.
- WAIT: alu_result is valid. Capture it into rsp_result, set rsp_valid=1, rsp_id=g, then go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_result stable until rsp_ready=1.
  - On the handshake edge: clear rsp_valid, go to IDLE.
- ALU drive outside EXEC: alu_opcode=3'b000 and operands 0. The ALU then outputs 0; this value is never captured.
- Latency: accept at cycle 0, response visible from cycle 3. Minimum issue interval is 4 cycles, so sustained throughput is 1 op per 4 cycles.
- Opcodes are passed through unchanged; unsupported opcodes (000, 110, 111) complete normally with result 0.
- Arithmetic is owned by the ALU. The result is a 16-bit wrapped two's complement value; MUL returns the low 16 bits.
- Requester obligations: req_valid/opcode/a/b must stay stable until req_ready. Dropping req_valid before grant is legal and loses nothing.
- Simultaneous events:
  - A new request arriving during EXEC/WAIT/RESP waits; no queueing inside the block.
  - A requester may re-request in the cycle after its response, but round-robin still favours the others.
- Fairness: any continuously valid requester is granted within N_REQ grants.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and the FSM, pointer and outputs return to reset values on the next edge.

Optional Feature:
- Macro: ALU_ARB_OVF_EN.
- With the macro: add output rsp_ovf (1 bit, reset 0), registered in WAIT alongside rsp_result and computed from the latched operands:
  - ADD/ADDI: a and b have the same sign and the result sign differs.
  - SUB/SUBI: a and b have different signs and the result sign differs from a.
  - MUL: the full 2*DATA_W product is not representable in DATA_W.
  - Other opcodes: 0.
- Without the macro: no port and no logic.

Decomposition:
- Package alu_pkg holds:
  - Opcode constants: NOP=3'b000, ADD=3'b001, ADDI=3'b010, SUB=3'b011, SUBI=3'b100, MUL=3'b101.
  - DATA_W.
  - FSM state encoding.
- Sub-module rr_arbiter (N_REQ parameter): inputs request vector and last_grant, outputs one-hot grant and grant index, purely combinational.
- The controller FSM stays in alu_arbiter.

Test Plan:
1. Single request, rsp_ready=1: req0 ADD a=100 b=-30 at cycle 0.
   - req_ready[0]=1 at cycle 0; rsp_valid at cycle 3 with rsp_id=0, rsp_result=70; busy low at cycle 4.
2. All four requesters valid continuously with SUB a=i b=1.
   - Grants in order 0,1,2,3,0; each response id matches, result=i-1; grants spaced 4 cycles apart.
3. Backpressure: MUL a=300 b=300 with rsp_ready=0 for 5 cycles.
   - rsp_result=0x5F90 (90000 mod 65536, signed 24464) held stable; no new grant until the handshake.
4. Wrap and sign: ADD a=32767 b=1.
   - rsp_result=-32768; with ALU_ARB_OVF_EN, rsp_ovf=1. ADD 5,6 gives rsp_ovf=0.
5. rst asserted during WAIT of an op from req2.
   - No rsp_valid; next cycle all outputs are at reset; with req0 and req2 both valid, req0 is granted first.
6. Opcode 3'b111, a=5 b=5.
   - Completes with rsp_result=0 after normal latency; arbitration continues unaffected.
